// File: rtl/mu_glb_arb_pkg.sv
// Shared types and constants for the matrix-unit / global-buffer request arbiter.
package mu_glb_arb_pkg;
  localparam int NUM_REQ     = 2;
  localparam int ARB_ADDR_W  = 21;
  localparam int ARB_SIZE_W  = 4;
  localparam int ARB_SRC_W   = 7;
  localparam int REQ_TAG_BIT = ARB_SRC_W - 1;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_SIZE_W-1:0] size;
    logic [ARB_SRC_W-1:0]  source;
  } tl_a_req_t;
endpackage

// File: rtl/mu_glb_outstanding_ctr.sv
// Per-requester outstanding-read counter; saturates at zero and flags underflow.
module mu_glb_outstanding_ctr #(
  parameter int MAX_OUT = 8,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          empty,
  output logic          underflow
);
  assign full      = (cnt >= CW'(MAX_OUT));
  assign empty     = (cnt == '0);
  assign underflow = dec && empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (inc && !dec)           cnt <= cnt + 1'b1;
    else if (dec && !inc && !empty) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/mu_glb_req_arbiter.sv
// Two-requester round-robin arbiter onto the unified MU/GLB request port,
// with tag-based response routing and per-requester outstanding limits.
module mu_glb_req_arbiter
  import mu_glb_arb_pkg::*;
#(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int SIZE_W  = ARB_SIZE_W,
  parameter int SRC_W   = ARB_SRC_W,
  parameter int DATA_W  = 256,
  parameter int MAX_OUT = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              r0_a_valid,
  output logic              r0_a_ready,
  input  logic [ADDR_W-1:0] r0_a_addr,
  input  logic [SIZE_W-1:0] r0_a_size,
  input  logic [SRC_W-2:0]  r0_a_source,
  output logic              r0_d_valid,
  input  logic              r0_d_ready,
  output logic [DATA_W-1:0] r0_d_data,
  output logic [SIZE_W-1:0] r0_d_size,
  output logic [SRC_W-2:0]  r0_d_source,
  output logic [2:0]        r0_d_opcode,
  input  logic              r1_a_valid,
  output logic              r1_a_ready,
  input  logic [ADDR_W-1:0] r1_a_addr,
  input  logic [SIZE_W-1:0] r1_a_size,
  input  logic [SRC_W-2:0]  r1_a_source,
  output logic              r1_d_valid,
  input  logic              r1_d_ready,
  output logic [DATA_W-1:0] r1_d_data,
  output logic [SIZE_W-1:0] r1_d_size,
  output logic [SRC_W-2:0]  r1_d_source,
  output logic [2:0]        r1_d_opcode,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [ADDR_W-1:0] out_a_addr,
  output logic [SIZE_W-1:0] out_a_size,
  output logic [SRC_W-1:0]  out_a_source,
  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [DATA_W-1:0] out_d_data,
  input  logic [SIZE_W-1:0] out_d_size,
  input  logic [SRC_W-1:0]  out_d_source,
  input  logic [2:0]        out_d_opcode,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [NUM_REQ-1:0]         a_valid, elig, a_fire, d_fire, full, empty, uflow;
  logic [NUM_REQ-1:0][CW-1:0] cnt;
  logic                       rr, gnt, slot_open, tag;
  tl_a_req_t                  slot;

  assign a_valid   = {r1_a_valid, r0_a_valid};
  assign elig      = a_valid & ~full;
  assign slot_open = !out_a_valid || out_a_ready;

  // Pointer decides only on a tie; a lone eligible requester always wins.
  always_comb begin
    gnt = rr;
    if (elig[0] && !elig[1])      gnt = 1'b0;
    else if (elig[1] && !elig[0]) gnt = 1'b1;
  end

  assign r0_a_ready = reset_n && slot_open && !gnt && elig[0];
  assign r1_a_ready = reset_n && slot_open &&  gnt && elig[1];
  assign a_fire     = {r1_a_ready && r1_a_valid, r0_a_ready && r0_a_valid};

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      slot        <= '0;
      out_a_valid <= 1'b0;
      rr          <= 1'b0;
    end else if (|a_fire) begin
      out_a_valid <= 1'b1;
      slot.addr   <= gnt ? r1_a_addr : r0_a_addr;
      slot.size   <= gnt ? r1_a_size : r0_a_size;
      slot.source <= {gnt, (gnt ? r1_a_source : r0_a_source)};
      rr          <= !gnt;
    end else if (out_a_ready) begin
      out_a_valid <= 1'b0;
    end
  end

  assign out_a_addr   = slot.addr;
  assign out_a_size   = slot.size;
  assign out_a_source = slot.source;

  assign tag         = out_d_source[SRC_W-1];
  assign r0_d_valid  = out_d_valid && !tag;
  assign r1_d_valid  = out_d_valid &&  tag;
  assign out_d_ready = tag ? r1_d_ready : r0_d_ready;
  assign d_fire      = {r1_d_valid && r1_d_ready, r0_d_valid && r0_d_ready};

  assign r0_d_data   = out_d_data;
  assign r1_d_data   = out_d_data;
  assign r0_d_size   = out_d_size;
  assign r1_d_size   = out_d_size;
  assign r0_d_source = out_d_source[SRC_W-2:0];
  assign r1_d_source = out_d_source[SRC_W-2:0];
  assign r0_d_opcode = out_d_opcode;
  assign r1_d_opcode = out_d_opcode;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_ctr
    mu_glb_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CW(CW)) u_ctr (
      .clk      (clk_in),
      .rst_n    (reset_n),
      .inc      (a_fire[g]),
      .dec      (d_fire[g]),
      .cnt      (cnt[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .underflow(uflow[g])
    );
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)    err <= 1'b0;
    else if (|uflow) err <= 1'b1;
  end

  assign busy = out_a_valid || !(&empty);
endmodule

// File: tb/tb_mu_glb_req_arbiter.sv
// Directed bench for mu_glb_req_arbiter with a scoreboard of expected downstream requests.
module tb_mu_glb_req_arbiter;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic reset_n;
  logic r0_a_valid, r0_a_ready, r0_d_valid, r0_d_ready;
  logic r1_a_valid, r1_a_ready, r1_d_valid, r1_d_ready;
  logic [20:0]  r0_a_addr, r1_a_addr, out_a_addr;
  logic [3:0]   r0_a_size, r1_a_size, r0_d_size, r1_d_size, out_a_size, out_d_size;
  logic [5:0]   r0_a_source, r1_a_source, r0_d_source, r1_d_source;
  logic [255:0] r0_d_data, r1_d_data, out_d_data;
  logic [2:0]   r0_d_opcode, r1_d_opcode, out_d_opcode;
  logic         out_a_valid, out_a_ready, out_d_valid, out_d_ready, busy, err;
  logic [6:0]   out_a_source, out_d_source;

  mu_glb_req_arbiter dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .r0_a_valid(r0_a_valid), .r0_a_ready(r0_a_ready), .r0_a_addr(r0_a_addr),
    .r0_a_size(r0_a_size), .r0_a_source(r0_a_source),
    .r0_d_valid(r0_d_valid), .r0_d_ready(r0_d_ready), .r0_d_data(r0_d_data),
    .r0_d_size(r0_d_size), .r0_d_source(r0_d_source), .r0_d_opcode(r0_d_opcode),
    .r1_a_valid(r1_a_valid), .r1_a_ready(r1_a_ready), .r1_a_addr(r1_a_addr),
    .r1_a_size(r1_a_size), .r1_a_source(r1_a_source),
    .r1_d_valid(r1_d_valid), .r1_d_ready(r1_d_ready), .r1_d_data(r1_d_data),
    .r1_d_size(r1_d_size), .r1_d_source(r1_d_source), .r1_d_opcode(r1_d_opcode),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_addr(out_a_addr),
    .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_data(out_d_data),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_opcode(out_d_opcode),
    .busy(busy), .err(err)
  );

  int total = 0, passed = 0, fails = 0;
  logic [31:0] sbq[$];
  logic rr_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req(input logic [20:0] a, input logic [3:0] s,
                                      input logic t, input logic [5:0] src);
    return {a, s, t, src};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic resp(input logic t, input logic [5:0] src);
    out_d_valid  = 1'b1;
    out_d_source = {t, src};
    tick();
    out_d_valid  = 1'b0;
  endtask

  // Downstream fires are observed mid-cycle; they complete at the following rising edge.
  always @(negedge clk_in) begin
    if (reset_n && out_a_valid && out_a_ready) begin
      if (sbq.size() == 0) check("sb_unexpected_req", {out_a_addr, out_a_size, out_a_source}, 0);
      else check("sb_req", {out_a_addr, out_a_size, out_a_source}, sbq.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0;
    r0_a_valid = 1'b1; r0_a_addr = '0; r0_a_size = '0; r0_a_source = '0; r0_d_ready = 1'b1;
    r1_a_valid = 1'b0; r1_a_addr = '0; r1_a_size = '0; r1_a_source = '0; r1_d_ready = 1'b1;
    out_a_ready = 1'b0; out_d_valid = 1'b0; out_d_data = '0; out_d_size = '0;
    out_d_source = '0; out_d_opcode = '0;
    rr_m = 1'b0;
    #1;
    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_out_a_fields", {out_a_addr, out_a_size, out_a_source}, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_r0_a_ready", r0_a_ready, 0);
    r0_a_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;

    // single requester round trip
    out_a_ready = 1'b1;
    r0_a_valid = 1'b1; r0_a_addr = 21'h00100; r0_a_size = 4'd5; r0_a_source = 6'h2A;
    sbq.push_back(req(21'h00100, 4'd5, 1'b0, 6'h2A));
    #1 check("t1_r0_a_ready", r0_a_ready, 1);
    tick();
    r0_a_valid = 1'b0; rr_m = 1'b1;
    #1;
    check("t1_out_a_valid", out_a_valid, 1);
    check("t1_out_a_source", out_a_source, 7'h2A);
    check("t1_cnt0", dut.cnt[0], 1);
    tick();
    out_d_valid = 1'b1; out_d_source = 7'h2A; out_d_data = {8{32'hC0DE_0001}};
    out_d_size = 4'd5; out_d_opcode = 3'd1;
    #1;
    check("t1_r0_d_valid", r0_d_valid, 1);
    check("t1_r0_d_source", r0_d_source, 6'h2A);
    check("t1_r1_d_valid", r1_d_valid, 0);
    check("t1_out_d_ready", out_d_ready, 1);
    check("t1_r0_d_data", r0_d_data, {8{32'hC0DE_0001}});
    check("t1_r1_d_opcode", r1_d_opcode, 3'd1);
    tick();
    out_d_valid = 1'b0;
    #1;
    check("t1_cnt0_back", dut.cnt[0], 0);
    check("t1_busy", busy, 0);

    // round-robin fairness, one request per cycle
    r0_a_addr = 21'h00200; r0_a_size = 4'd1; r0_a_source = 6'h11;
    r1_a_addr = 21'h00300; r1_a_size = 4'd2; r1_a_source = 6'h22;
    r0_a_valid = 1'b1; r1_a_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sbq.push_back(rr_m ? req(21'h00300, 4'd2, 1'b1, 6'h22) : req(21'h00200, 4'd1, 1'b0, 6'h11));
      rr_m = !rr_m;
      tick();
    end
    r0_a_valid = 1'b0; r1_a_valid = 1'b0;
    #1;
    check("t2_cnt0", dut.cnt[0], 4);
    check("t2_cnt1", dut.cnt[1], 4);
    for (int i = 0; i < 8; i++) begin
      logic tg;
      tg = i[0];
      out_d_valid = 1'b1; out_d_source = {tg, 6'(i)};
      #1;
      check("t2_r0_d_valid", r0_d_valid, !tg);
      check("t2_r1_d_valid", r1_d_valid, tg);
      tick();
    end
    out_d_valid = 1'b0;
    #1;
    check("t2_cnt0_clear", dut.cnt[0], 0);
    check("t2_cnt1_clear", dut.cnt[1], 0);

    // outstanding limit on requester 0
    r0_a_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r0_a_addr = 21'(32'h400 + i); r0_a_size = 4'd3; r0_a_source = 6'(i);
      sbq.push_back(req(21'(32'h400 + i), 4'd3, 1'b0, 6'(i)));
      rr_m = 1'b1;
      tick();
    end
    r1_a_valid = 1'b1; r1_a_addr = 21'h00333; r1_a_size = 4'd4; r1_a_source = 6'h33;
    sbq.push_back(req(21'h00333, 4'd4, 1'b1, 6'h33));
    #1;
    check("t3_r0_stalled", r0_a_ready, 0);
    check("t3_r1_granted", r1_a_ready, 1);
    check("t3_cnt0_full", dut.cnt[0], 8);
    tick();
    r1_a_valid = 1'b0; rr_m = 1'b0;
    out_d_valid = 1'b1; out_d_source = {1'b0, 6'h00};
    #1 check("t3_r0_still_stalled", r0_a_ready, 0);
    tick();
    out_d_valid = 1'b0;
    r0_a_addr = 21'h004FF; r0_a_source = 6'h3F;
    sbq.push_back(req(21'h004FF, 4'd3, 1'b0, 6'h3F));
    #1 check("t3_r0_reenabled", r0_a_ready, 1);
    tick();
    r0_a_valid = 1'b0; rr_m = 1'b1;
    for (int i = 0; i < 8; i++) resp(1'b0, 6'(i));
    resp(1'b1, 6'h33);
    #1;
    check("t3_cnt0_clear", dut.cnt[0], 0);
    check("t3_cnt1_clear", dut.cnt[1], 0);

    // downstream backpressure with the slot full
    out_a_ready = 1'b0;
    r0_a_valid = 1'b1; r0_a_addr = 21'h00500; r0_a_size = 4'd3; r0_a_source = 6'h05;
    sbq.push_back(req(21'h00500, 4'd3, 1'b0, 6'h05));
    tick();
    rr_m = 1'b1;
    r1_a_valid = 1'b1; r1_a_addr = 21'h00600; r1_a_size = 4'd2; r1_a_source = 6'h06;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_slot_fields", {out_a_valid, out_a_addr, out_a_size, out_a_source},
            {1'b1, req(21'h00500, 4'd3, 1'b0, 6'h05)});
      check("t4_a_ready", {r1_a_ready, r0_a_ready}, 2'b00);
      check("t4_cnts", {dut.cnt[1], dut.cnt[0]}, {4'd0, 4'd1});
      tick();
    end
    out_a_ready = 1'b1;
    sbq.push_back(req(21'h00600, 4'd2, 1'b1, 6'h06));
    #1 check("t4_b2b_r1_ready", r1_a_ready, rr_m);
    tick();
    r0_a_valid = 1'b0; r1_a_valid = 1'b0; rr_m = 1'b0;
    tick();

    // simultaneous inc/dec on requester 1, then underflow
    resp(1'b0, 6'h05);
    r1_a_valid = 1'b1; r1_a_addr = 21'h00700; r1_a_size = 4'd1; r1_a_source = 6'h07;
    sbq.push_back(req(21'h00700, 4'd1, 1'b1, 6'h07));
    out_d_valid = 1'b1; out_d_source = {1'b1, 6'h06};
    #1;
    check("t5_r1_a_ready", r1_a_ready, 1);
    check("t5_r1_d_valid", r1_d_valid, 1);
    tick();
    r1_a_valid = 1'b0; out_d_valid = 1'b0;
    #1;
    check("t5_cnt1_unchanged", dut.cnt[1], 1);
    check("t5_busy", busy, 1);
    r1_d_ready = 1'b0; out_d_valid = 1'b1; out_d_source = {1'b1, 6'h07};
    #1 check("t5_out_d_ready_bp", out_d_ready, 0);
    tick();
    #1 check("t5_cnt1_no_fire", dut.cnt[1], 1);
    r1_d_ready = 1'b1;
    tick();
    out_d_valid = 1'b0;
    #1;
    check("t5_cnt1_zero", dut.cnt[1], 0);
    check("t5_err_clean", err, 0);
    resp(1'b1, 6'h07);
    #1;
    check("t5_err_set", err, 1);
    check("t5_cnt1_sat", dut.cnt[1], 0);
    tick(); tick(); tick();
    check("t5_err_sticky", err, 1);

    // reset mid-operation with slot full and cnt0 == 3
    r0_a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0_a_addr = 21'(32'h800 + i); r0_a_size = 4'd2; r0_a_source = 6'(32'h10 + i);
      sbq.push_back(req(21'(32'h800 + i), 4'd2, 1'b0, 6'(32'h10 + i)));
      tick();
    end
    out_a_ready = 1'b0; r0_a_valid = 1'b0;
    #1;
    check("t6_slot_full", out_a_valid, 1);
    check("t6_cnt0", dut.cnt[0], 3);
    void'(sbq.pop_back());
    r0_a_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t6_out_a_valid", out_a_valid, 0);
    check("t6_cnts", {dut.cnt[1], dut.cnt[0]}, 0);
    check("t6_busy", busy, 0);
    check("t6_err_cleared", err, 0);
    check("t6_r0_a_ready", r0_a_ready, 0);
    tick();
    r0_a_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check("t6_rr", dut.rr, 0);
    check("t6_out_a_source", out_a_source, 0);
    check("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
